// File: rtl/ksa_pkg.sv
// ksa_pkg: shared constants and helpers for the pipelined Kogge-Stone adder.
//   ksa_op_e       - operation encoding carried alongside each beat
//   ksa_clog2      - ceil(log2(n)), usable in parameter context
//   ksa_num_groups - number of registered prefix groups for a width/levels-per-stage pair
package ksa_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } ksa_op_e;

    // Widths are bounded at 128, so eight candidate exponents cover every legal case.
    function automatic int ksa_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int ksa_num_groups(input int width, input int lps);
        return (ksa_clog2(width) + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/ksa_prefix_group.sv
// ksa_prefix_group: COUNT Kogge-Stone prefix levels starting at level START,
// followed by a pipeline register.
//   clk, rst_n   - clock, synchronous active-low reset (clears the valid bit only)
//   en           - global advance enable
//   vld          - beat valid into this group
//   g, p         - group generate/propagate entering the first level
//   pt           - original bitwise propagate, passed through for the final sum
//   cin          - effective carry-in, passed through
//   vld_q .. cin_q - registered versions after the prefix levels
module ksa_prefix_group #(
    parameter int WIDTH = 32,
    parameter int START = 0,
    parameter int COUNT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             vld,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] pt,
    input  logic             cin,
    output logic             vld_q,
    output logic [WIDTH-1:0] g_q,
    output logic [WIDTH-1:0] p_q,
    output logic [WIDTH-1:0] pt_q,
    output logic             cin_q
);

    logic [WIDTH-1:0] g_c;
    logic [WIDTH-1:0] p_c;

    // Bits below the level distance already span down to bit 0; the shift
    // brings in zeros there so they stay unchanged.
    always_comb begin
        g_c = g;
        p_c = p;
        for (int k = 0; k < COUNT; k++) begin
            g_c = g_c | (p_c & (g_c << (1 << (START + k))));
            p_c = p_c & (p_c << (1 << (START + k)));
        end
    end

    // ---- group register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (en) begin
            vld_q <= vld;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            g_q   <= g_c;
            p_q   <= p_c;
            pt_q  <= pt;
            cin_q <= cin;
        end
    end

endmodule

// File: rtl/ksa_pipe.sv
// ksa_pipe: pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid, in_ready  - operand beat handshake (in_ready = global advance)
//   A, B, CIN, SUB      - operands, carry-in (ADD only), 1 = A-B
//   out_valid, out_ready- result beat handshake
//   SUM, COUT, OVERFLOW, ZERO - registered result and flags
// One stage of bitwise G/P, NG registered prefix groups, one result stage.
module ksa_pipe
    import ksa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LPS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVERFLOW,
    output logic             ZERO
);

    localparam int LEVELS = ksa_clog2(WIDTH);
    localparam int NG     = ksa_num_groups(WIDTH, LPS);

    logic             adv;
    ksa_op_e          op;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH-1:0] p_c;
    logic [WIDTH-1:0] g_c;

    logic             vld_p0;
    logic [WIDTH-1:0] g_p0;
    logic [WIDTH-1:0] p_p0;
    logic             cin_p0;

    logic             vld_s [0:NG];
    logic [WIDTH-1:0] g_s   [0:NG];
    logic [WIDTH-1:0] p_s   [0:NG];
    logic [WIDTH-1:0] pt_s  [0:NG];
    logic             cin_s [0:NG];

    logic [WIDTH-1:0] carry_c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] p_unused;

    // The whole pipe freezes when a result is held for a stalled consumer.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign op      = ksa_op_e'(SUB);
    assign b_eff   = (op == OP_SUB) ? ~B : B;
    assign cin_eff = (op == OP_SUB) ? 1'b1 : CIN;
    assign p_c     = A ^ b_eff;
    // Carry-in is folded into bit 0's generate so every prefix G[i] is the
    // true carry out of bit i.
    assign g_c     = (A & b_eff) | {{(WIDTH-1){1'b0}}, p_c[0] & cin_eff};

    // ---- stage 0: bitwise generate/propagate ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            g_p0   <= g_c;
            p_p0   <= p_c;
            cin_p0 <= cin_eff;
        end
    end

    assign vld_s[0] = vld_p0;
    assign g_s[0]   = g_p0;
    assign p_s[0]   = p_p0;
    assign pt_s[0]  = p_p0;
    assign cin_s[0] = cin_p0;

    // ---- stages 1..NG: prefix groups ----
    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int START = k * LPS;
        localparam int CNT   = ((LEVELS - START) < LPS) ? (LEVELS - START) : LPS;

        ksa_prefix_group #(
            .WIDTH (WIDTH),
            .START (START),
            .COUNT (CNT)
        ) u_grp (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .vld   (vld_s[k]),
            .g     (g_s[k]),
            .p     (p_s[k]),
            .pt    (pt_s[k]),
            .cin   (cin_s[k]),
            .vld_q (vld_s[k+1]),
            .g_q   (g_s[k+1]),
            .p_q   (p_s[k+1]),
            .pt_q  (pt_s[k+1]),
            .cin_q (cin_s[k+1])
        );
    end

    assign p_unused = p_s[NG];
    assign carry_c  = {g_s[NG][WIDTH-2:0], cin_s[NG]};
    assign sum_c    = pt_s[NG] ^ carry_c;

    // ---- final stage: result and flags ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            SUM       <= '0;
            COUT      <= 1'b0;
            OVERFLOW  <= 1'b0;
            ZERO      <= 1'b0;
        end else if (adv) begin
            out_valid <= vld_s[NG];
            SUM       <= sum_c;
            COUT      <= g_s[NG][WIDTH-1];
            OVERFLOW  <= g_s[NG][WIDTH-1] ^ carry_c[WIDTH-1];
            ZERO      <= ~|sum_c;
        end
    end

endmodule

// File: tb/tb_ksa_pipe.sv
// tb_ksa_pipe: directed table vectors, reset sequences and scoreboarded streams
// across four ksa_pipe configurations sharing one stimulus bus.
module tb_ksa_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_n, in_valid, CIN, SUB, out_ready;
    logic [127:0] a_drv, b_drv;

    logic        rdy0, vld0, co0, ovf0, z0;  logic [31:0] sum0;   // 32 / LPS 1
    logic        rdy1, vld1, co1, ovf1, z1;  logic [31:0] sum1;   // 32 / LPS 5
    logic        rdy2, vld2, co2, ovf2, z2;  logic [7:0]  sum2;   // 8  / LPS 2
    logic        rdy3, vld3, co3, ovf3, z3;  logic [12:0] sum3;   // 13 / LPS 3

    ksa_pipe #(.WIDTH(32), .LPS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .A(a_drv[31:0]), .B(b_drv[31:0]), .CIN(CIN), .SUB(SUB),
        .out_valid(vld0), .out_ready(out_ready), .SUM(sum0), .COUT(co0),
        .OVERFLOW(ovf0), .ZERO(z0));
    ksa_pipe #(.WIDTH(32), .LPS(5)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .A(a_drv[31:0]), .B(b_drv[31:0]), .CIN(CIN), .SUB(SUB),
        .out_valid(vld1), .out_ready(out_ready), .SUM(sum1), .COUT(co1),
        .OVERFLOW(ovf1), .ZERO(z1));
    ksa_pipe #(.WIDTH(8), .LPS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .A(a_drv[7:0]), .B(b_drv[7:0]), .CIN(CIN), .SUB(SUB),
        .out_valid(vld2), .out_ready(out_ready), .SUM(sum2), .COUT(co2),
        .OVERFLOW(ovf2), .ZERO(z2));
    ksa_pipe #(.WIDTH(13), .LPS(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
        .A(a_drv[12:0]), .B(b_drv[12:0]), .CIN(CIN), .SUB(SUB),
        .out_valid(vld3), .out_ready(out_ready), .SUM(sum3), .COUT(co3),
        .OVERFLOW(ovf3), .ZERO(z3));

    int           sel;
    logic         rdy_m, vld_m, co_m, ovf_m, z_m;
    logic [127:0] sum_m;

    always_comb begin
        rdy_m = rdy0; vld_m = vld0; sum_m = {96'd0, sum0}; co_m = co0; ovf_m = ovf0; z_m = z0;
        case (sel)
            1: begin rdy_m = rdy1; vld_m = vld1; sum_m = {96'd0, sum1};  co_m = co1; ovf_m = ovf1; z_m = z1; end
            2: begin rdy_m = rdy2; vld_m = vld2; sum_m = {120'd0, sum2}; co_m = co2; ovf_m = ovf2; z_m = z2; end
            3: begin rdy_m = rdy3; vld_m = vld3; sum_m = {115'd0, sum3}; co_m = co3; ovf_m = ovf3; z_m = z3; end
            default: ;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, overflow from operand/result sign bits.
    function automatic logic [130:0] model(input int w, input logic [127:0] a, input logic [127:0] b,
                                           input logic cin, input logic sub);
        logic [128:0] mask, full;
        logic [127:0] bb, s;
        logic         co, ov;
        mask = (129'd1 << w) - 129'd1;
        bb   = sub ? ~b : b;
        full = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + (sub ? 129'd1 : {128'd0, cin});
        s    = full[127:0] & mask[127:0];
        co   = full[w];
        ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
        return {s, co, ov, (s == 128'd0)};
    endfunction

    function automatic logic [131:0] outs();
        return {vld_m, sum_m, co_m, ovf_m, z_m};
    endfunction

    // Single beat into an idle pipe; checks acceptance, latency and result.
    task automatic apply_one(input string name, input int s, input logic sub_i, input logic cin_i,
                             input logic [127:0] a_i, input logic [127:0] b_i,
                             input logic [130:0] exp, input int lat);
        int acc, t;
        sel = s;
        @(posedge clk); #1;
        a_drv = a_i; b_drv = b_i; SUB = sub_i; CIN = cin_i; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check({name, "/in_ready"}, 132'(rdy_m), 132'd1);
        acc = cyc;
        @(posedge clk); #1;
        a_drv = ~a_i; b_drv = ~b_i; SUB = ~sub_i; CIN = ~cin_i; in_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!vld_m && t < 20);
        check({name, "/latency"}, 132'(cyc - acc), 132'(lat));
        check({name, "/result"}, 132'({sum_m, co_m, ovf_m, z_m}), 132'(exp));
    endtask

    // mode 0: random beats, out_ready 1,0,0,1...; mode 1: exhaustive 8-bit ADD CIN=1;
    // mode 2: random beats, out_ready held high.
    task automatic stream(input string name, input int s, input int w, input int nbeats,
                          input int mode, input int lat);
        logic [130:0] q[$];
        logic [130:0] held, exp;
        logic [127:0] ca, cb;
        logic         csub, ccin, stalled;
        int           sent, got, acc0, first_out;
        sel = s; sent = 0; got = 0; acc0 = -1; first_out = -1; stalled = 1'b0; held = '0;
        ca = '0; cb = '0; csub = 1'b0; ccin = 1'b0;
        for (int t = 0; t < nbeats * 3 + 50 && got < nbeats; t++) begin
            if (mode == 1) begin
                ca = 128'(sent >> 8); cb = 128'(sent & 255); csub = 1'b0; ccin = 1'b1;
            end else if (t == 0 || (in_valid && rdy_m)) begin
                ca = {$urandom, $urandom, $urandom, $urandom};
                cb = {$urandom, $urandom, $urandom, $urandom};
                csub = 1'($urandom_range(0, 1)); ccin = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            in_valid  = (sent < nbeats);
            a_drv = ca; b_drv = cb; SUB = csub; CIN = ccin;
            out_ready = (mode == 0) ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (stalled) check({name, "/stall_hold"}, outs(), {1'b1, held});
            if (vld_m && first_out < 0) first_out = cyc;
            if (vld_m && out_ready) begin
                if (q.size() == 0) begin
                    check({name, "/extra_beat"}, 132'd1, 132'd0);
                end else begin
                    exp = q.pop_front();
                    check({name, "/beat"}, 132'({sum_m, co_m, ovf_m, z_m}), 132'(exp));
                end
                got++;
            end
            stalled = vld_m && !out_ready;
            held    = {sum_m, co_m, ovf_m, z_m};
            if (in_valid && rdy_m) begin
                if (acc0 < 0) acc0 = cyc;
                q.push_back(model(w, ca, cb, ccin, csub));
                sent++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        check({name, "/latency"}, 132'(first_out - acc0), 132'(lat));
        check({name, "/beats_out"}, 132'(got), 132'(nbeats));
        check({name, "/leftover"}, 132'(q.size()), 132'd0);
    endtask

    typedef struct {
        logic        sub;
        logic        cin;
        logic [31:0] a, b, s;
        logic        co, ov, z;
    } vec_t;

    vec_t vecs [12];
    int   seen;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h00000001, 32'h00000002, 32'h00000004, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 32'h0000000A, 32'h00000003, 32'h00000007, 1'b1, 1'b0, 1'b0};

        sel = 0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_drv = '0; b_drv = '0; SUB = 1'b0; CIN = 1'b0;

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/outputs", outs(), 132'd0);
        check("reset/in_ready", 132'(rdy_m), 132'd1);
        sel = 3;
        check("reset/outputs_w13", outs(), 132'd0);
        sel = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed table on both 32-bit configurations
        for (int i = 0; i < 12; i++) begin
            apply_one($sformatf("vec%0d_lps1", i), 0, vecs[i].sub, vecs[i].cin,
                      {96'd0, vecs[i].a}, {96'd0, vecs[i].b},
                      {96'd0, vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].z}, 7);
        end
        for (int i = 0; i < 12; i++) begin
            apply_one($sformatf("vec%0d_lps5", i), 1, vecs[i].sub, vecs[i].cin,
                      {96'd0, vecs[i].a}, {96'd0, vecs[i].b},
                      {96'd0, vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].z}, 3);
        end

        // Reset with four beats in flight and a fifth presented on the reset edge
        sel = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_drv = 128'(i + 1); b_drv = 128'd100; SUB = 1'b0; CIN = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst_n = 1'b0; a_drv = 128'h55; in_valid = 1'b1;
        @(negedge clk);
        check("rst_mid/in_ready_during", 132'(rdy_m), 132'd1);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid/outputs", outs(), 132'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (vld_m) seen++;
        end
        check("rst_mid/no_stale_beats", 132'(seen), 132'd0);
        apply_one("rst_mid/next_beat", 0, 1'b0, 1'b0, 128'h0000_1000, 128'h0000_0234,
                  model(32, 128'h0000_1000, 128'h0000_0234, 1'b0, 1'b0), 7);

        stream("stream_w32", 0, 32, 16, 0, 7);
        stream("stream_w32_lps5", 1, 32, 40, 2, 3);
        stream("exhaustive_w8", 2, 8, 65536, 1, 4);
        stream("stream_w13", 3, 13, 1000, 0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ksa_pipe.md
KSA_PIPE -- requirements
Module: ksa_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits, legal range 2..128.
REQ-002 Parameter LPS, default 1, Kogge-Stone prefix levels per pipeline register group, legal range 1..clog2(WIDTH).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 A, B  input  WIDTH each  operands.
REQ-008 CIN  input  1  carry-in, used in ADD mode only.
REQ-009 SUB  input  1  0 = A+B+CIN, 1 = A-B (A + ~B + 1; CIN ignored).
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 SUM  output  WIDTH  result, low WIDTH bits.
REQ-013 COUT  output  1  carry out of MSB (for SUB: 1 = no borrow).
REQ-014 OVERFLOW  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
REQ-015 ZERO  output  1  SUM == 0.

Function
REQ-016 Transfer on a port occurs when valid and ready are both 1 on the same rising edge.
REQ-017 Pipeline stage 0 SHALL register operands as bitwise generate/propagate plus effective carry-in.
REQ-018 NG = ceil(clog2(WIDTH)/LPS) prefix groups, each ending in a register; last group may hold fewer than LPS levels.
REQ-019 Final stage SHALL register SUM, COUT, OVERFLOW, ZERO; latency accept-to-out_valid = NG+2 cycles with no stall (WIDTH=32, LPS=1: 7; LPS=5: 3).
REQ-020 Each stage carries a valid bit; SUM/flags are don't-care when out_valid=0 but SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Global advance enable adv = !out_valid || out_ready; all stages shift only when adv=1; in_ready = adv.
REQ-022 Throughput one beat per cycle while out_ready=1; no bubble inserted on stall release.
REQ-023 Back-to-back mixed ADD/SUB beats SHALL each use their own SUB/CIN (mode travels with data).
REQ-024 in_ready SHALL not depend combinationally on in_valid.
REQ-025 Results SHALL be bit-exact to (A + (SUB ? ~B : B) + (SUB ? 1 : CIN)) mod 2^WIDTH; carry wrap at all-ones operands must set COUT=1 with SUM per modulo rule.

Reset
REQ-026 rst_n=0 on rising edge SHALL clear every stage valid bit; out_valid=0, SUM=0, COUT=0, OVERFLOW=0, ZERO=0 from the next cycle.
REQ-027 in_ready SHALL be 1 during and after reset (adv true since out_valid=0).
REQ-028 Reset mid-operation SHALL discard all in-flight beats; no partial result emitted afterwards.
REQ-029 Beat presented on the reset edge SHALL NOT be accepted.

Structure
REQ-030 Package ksa_pkg SHALL hold clog2-based constant function, NG computation function, and the ADD/SUB op encoding.
REQ-031 One sub-module ksa_prefix_group SHALL implement up to LPS prefix levels (parameterised start level and count) plus its output register and valid bit, instantiated NG times.
REQ-032 No latches; no multicycle paths; only clk drives flops.

Verification
REQ-033 WIDTH=32, LPS=1, ADD, A=0xFFFFFFFF, B=0x00000001, CIN=0 -> after 7 cycles SUM=0x00000000, COUT=1, OVERFLOW=0, ZERO=1.
REQ-034 WIDTH=32, ADD, A=0x7FFFFFFF, B=0x00000001 -> SUM=0x80000000, COUT=0, OVERFLOW=1; SUB, A=5, B=7 -> SUM=0xFFFFFFFE, COUT=0, OVERFLOW=0.
REQ-035 Stream 16 random beats with out_ready toggling 1,0,0,1...; scoreboard order and values exact, SUM stable during every stall, no beats lost or duplicated.
REQ-036 Assert rst_n=0 for one cycle with 4 beats in flight -> out_valid=0 next cycle, those 4 results never appear, next accepted beat emerges NG+2 cycles later.
REQ-037 WIDTH=8, LPS=2 (NG=2) exhaustive 65536 ADD pairs with CIN=1 -> latency 4, all results match reference model.
REQ-038 WIDTH=13 (non-power-of-2), LPS=3 -> 1000 random ADD/SUB beats match model, latency NG+2=4.
